// File: rtl/video_lvds_pkg.sv
// video_lvds_pkg: definitions shared by the 7:1 LVDS video transmitter and
// receiver.
//   - word and colour widths
//   - the clock-lane framing pattern
//   - lock FSM states
//   - the bit position of every field inside the three data-lane words
//   - a helper that unpacks three lane words into one pixel
package video_lvds_pkg;

  localparam int WORD_BITS  = 7;
  localparam int COLOR_BITS = 6;

  // Clock lane carries two high, three low, two high per pixel.
  localparam logic [WORD_BITS-1:0] CLK_PATTERN = 7'b1100011;

  // Lane map, word bit positions (bit 6 is sent first).
  // ch1 = R0..R5 (descending from R0_POS), G0
  localparam int R0_POS = 6;
  localparam int G0_POS = 0;
  // ch2 = G1..G5 (descending from G1_POS), B0, B1
  localparam int G1_POS = 6;
  localparam int B0_POS = 1;
  localparam int B1_POS = 0;
  // ch3 = B2..B5 (descending from B2_POS), HSync, VSync, DataEnable
  localparam int B2_POS    = 6;
  localparam int HSYNC_POS = 2;
  localparam int VSYNC_POS = 1;
  localparam int DE_POS    = 0;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
  } pixel_t;

  localparam int PIXEL_BITS = $bits(pixel_t);

  // Reassemble one pixel from the three data-lane words.
  // Colour index 0 is the LSB of each colour.
  function automatic pixel_t unpack_pixel(input logic [WORD_BITS-1:0] w1,
                                          input logic [WORD_BITS-1:0] w2,
                                          input logic [WORD_BITS-1:0] w3);
    pixel_t p;
    p.red   = {w1[R0_POS-5], w1[R0_POS-4], w1[R0_POS-3],
               w1[R0_POS-2], w1[R0_POS-1], w1[R0_POS]};
    p.green = {w2[G1_POS-4], w2[G1_POS-3], w2[G1_POS-2],
               w2[G1_POS-1], w2[G1_POS],   w1[G0_POS]};
    p.blue  = {w3[B2_POS-3], w3[B2_POS-2], w3[B2_POS-1],
               w3[B2_POS],   w2[B1_POS],   w2[B0_POS]};
    p.hsync = w3[HSYNC_POS];
    p.vsync = w3[VSYNC_POS];
    p.de    = w3[DE_POS];
    return p;
  endfunction

endpackage

// File: rtl/video_lvds_rx_if.sv
// video_lvds_rx_if: bundle between the LVDS samplers, the receiver and the
// panel-side video pipeline.
//   channel1_in..channel3_in, clock_in : sampled LVDS lanes (into receiver)
//   Red, Green, Blue, HSync, VSync,
//   DataEnable, pixel_valid, locked    : recovered video (out of receiver)
// slave is the receiver's view; master is the view of whatever surrounds it
// (lane source and video sink).
interface video_lvds_rx_if;
  import video_lvds_pkg::*;

  logic                  channel1_in;
  logic                  channel2_in;
  logic                  channel3_in;
  logic                  clock_in;
  logic [COLOR_BITS-1:0] Red;
  logic [COLOR_BITS-1:0] Green;
  logic [COLOR_BITS-1:0] Blue;
  logic                  HSync;
  logic                  VSync;
  logic                  DataEnable;
  logic                  pixel_valid;
  logic                  locked;

  modport master (
    output channel1_in, channel2_in, channel3_in, clock_in,
    input  Red, Green, Blue, HSync, VSync, DataEnable, pixel_valid, locked
  );

  modport slave (
    input  channel1_in, channel2_in, channel3_in, clock_in,
    output Red, Green, Blue, HSync, VSync, DataEnable, pixel_valid, locked
  );
endinterface

// File: rtl/lvds_deser_lane.sv
// lvds_deser_lane: 7-bit MSB-first deserializer for one LVDS lane.
//   clk     : bit clock
//   rst     : asynchronous active-high reset
//   lane_in : sampled lane bit
//   word    : last seven bits received, oldest bit in word[6]
module lvds_deser_lane
  import video_lvds_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lane_in,
  output logic [WORD_BITS-1:0] word
);

  // Shift one bit in per clock; the word is complete whenever the framing
  // logic says it is, no alignment is done here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= {WORD_BITS{1'b0}};
    end else begin
      word <= {word[WORD_BITS-2:0], lane_in};
    end
  end

endmodule

// File: rtl/video_lvds_rx.sv
// video_lvds_rx: 7:1 LVDS video receiver.
//   clk : 7x pixel-rate bit clock
//   rst : asynchronous active-high reset
//   bus : lanes in (channel1..3_in, clock_in); RGB666, HSync, VSync,
//         DataEnable, pixel_valid strobe and locked out
// Word alignment comes from the clock-lane pattern: SEARCH looks for it on
// every cycle, VERIFY confirms it on the 7-cycle grid, LOCKED decodes pixels
// and tolerates isolated bad clock words.
module video_lvds_rx
  import video_lvds_pkg::*;
#(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 2
) (
  input  logic           clk,
  input  logic           rst,
  video_lvds_rx_if.slave bus
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_ERRORS) ? LOCK_COUNT : UNLOCK_ERRORS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_TARGET   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_TARGET = CNT_W'(UNLOCK_ERRORS);
  localparam logic [2:0]       PH_LAST       = 3'd6;

  logic [WORD_BITS-1:0] word_ch1;
  logic [WORD_BITS-1:0] word_ch2;
  logic [WORD_BITS-1:0] word_ch3;
  logic [WORD_BITS-1:0] word_clk;

  lock_state_t      state;
  lock_state_t      next_state;
  logic [2:0]       ph;
  logic [2:0]       ph_next;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] good_next;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] err_next;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] err_inc;
  logic             pattern_ok;
  logic             boundary;
  logic             capture;

  pixel_t           pix;
  logic             pixel_strobe;
  logic             locked_reg;

  lvds_deser_lane u_lane_ch1 (.clk(clk), .rst(rst), .lane_in(bus.channel1_in), .word(word_ch1));
  lvds_deser_lane u_lane_ch2 (.clk(clk), .rst(rst), .lane_in(bus.channel2_in), .word(word_ch2));
  lvds_deser_lane u_lane_ch3 (.clk(clk), .rst(rst), .lane_in(bus.channel3_in), .word(word_ch3));
  lvds_deser_lane u_lane_clk (.clk(clk), .rst(rst), .lane_in(bus.clock_in),    .word(word_clk));

  assign pattern_ok = (word_clk == CLK_PATTERN);
  // ph==6 means the registers hold a full word on the established grid.
  assign boundary   = (ph == PH_LAST);
  assign good_inc   = good_cnt + CNT_ONE;
  assign err_inc    = err_cnt + CNT_ONE;

  // Next-state, counter and capture decisions for the lock FSM.
  always_comb begin
    next_state = state;
    ph_next    = ph;
    good_next  = good_cnt;
    err_next   = err_cnt;
    capture    = 1'b0;
    case (state)
      SEARCH: begin
        // Every cycle is a candidate boundary; a match fixes the grid.
        if (pattern_ok) begin
          next_state = VERIFY;
          ph_next    = 3'd0;
          good_next  = CNT_ONE;
        end else begin
          next_state = SEARCH;
        end
      end
      VERIFY: begin
        ph_next = boundary ? 3'd0 : ph + 3'd1;
        if (boundary) begin
          if (pattern_ok) begin
            good_next = good_inc;
            if (good_inc == LOCK_TARGET) begin
              next_state = LOCKED;
              err_next   = CNT_ZERO;
            end else begin
              next_state = VERIFY;
            end
          end else begin
            next_state = SEARCH;
            good_next  = CNT_ZERO;
          end
        end else begin
          next_state = VERIFY;
        end
      end
      LOCKED: begin
        ph_next = boundary ? 3'd0 : ph + 3'd1;
        if (boundary) begin
          if (pattern_ok) begin
            capture  = 1'b1;
            err_next = CNT_ZERO;
          end else begin
            err_next = err_inc;
            if (err_inc == UNLOCK_TARGET) begin
              next_state = SEARCH;
              good_next  = CNT_ZERO;
            end else begin
              next_state = LOCKED;
            end
          end
        end else begin
          next_state = LOCKED;
        end
      end
      default: begin
        next_state = SEARCH;
        ph_next    = 3'd0;
        good_next  = CNT_ZERO;
        err_next   = CNT_ZERO;
      end
    endcase
  end

  // Lock FSM state, phase and good/error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      ph       <= 3'd0;
      good_cnt <= CNT_ZERO;
      err_cnt  <= CNT_ZERO;
    end else begin
      state    <= next_state;
      ph       <= ph_next;
      good_cnt <= good_next;
      err_cnt  <= err_next;
    end
  end

  // Output registers: pixel fields hold their last capture, even across
  // loss of lock; locked tracks the state register edge-for-edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix          <= {PIXEL_BITS{1'b0}};
      pixel_strobe <= 1'b0;
      locked_reg   <= 1'b0;
    end else begin
      pixel_strobe <= capture;
      locked_reg   <= (next_state == LOCKED);
      if (capture) begin
        pix <= unpack_pixel(word_ch1, word_ch2, word_ch3);
      end
    end
  end

  assign bus.Red         = pix.red;
  assign bus.Green       = pix.green;
  assign bus.Blue        = pix.blue;
  assign bus.HSync       = pix.hsync;
  assign bus.VSync       = pix.vsync;
  assign bus.DataEnable  = pix.de;
  assign bus.pixel_valid = pixel_strobe;
  assign bus.locked      = locked_reg;

endmodule

// File: tb/tb_video_lvds_rx.sv
// tb_video_lvds_rx: directed bench for video_lvds_rx.
// Lanes are driven on the falling edge; a monitor on the falling edge logs
// strobes (edge index + pixel) and locked transitions for later checking.
module tb_video_lvds_rx;
  import video_lvds_pkg::*;

  localparam logic [6:0] CP     = 7'b1100011;
  localparam logic [6:0] BAD_CP = 7'b1100010;
  // R=2A G=15 B=3C H=1 V=0 DE=1
  localparam logic [20:0] P1 = {6'h2A, 6'h15, 6'h3C, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  video_lvds_rx_if bus ();

  video_lvds_rx #(.LOCK_COUNT(4), .UNLOCK_ERRORS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int          sv_cyc[$];
  logic [20:0] sv_pix[$];
  int          rise_cyc[$];
  int          fall_cyc[$];
  logic        prev_locked = 1'b0;
  int          snap_at = -1;
  logic [20:0] snap_pix;
  logic        snap_locked;
  logic        snap_valid;

  function automatic logic [20:0] out_pix();
    return {bus.Red, bus.Green, bus.Blue, bus.HSync, bus.VSync, bus.DataEnable};
  endfunction

  initial forever begin
    @(negedge clk);
    if (bus.pixel_valid === 1'b1) begin
      sv_cyc.push_back(cyc);
      sv_pix.push_back(out_pix());
    end
    if (bus.locked === 1'b1 && prev_locked !== 1'b1) rise_cyc.push_back(cyc);
    if (bus.locked !== 1'b1 && prev_locked === 1'b1) fall_cyc.push_back(cyc);
    prev_locked = bus.locked;
    if (cyc == snap_at) begin
      snap_pix    = out_pix();
      snap_locked = bus.locked;
      snap_valid  = bus.pixel_valid;
    end
  end

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [20:0] pix_at(input int i);
    if (i < sv_pix.size()) return sv_pix[i];
    return 21'bx;
  endfunction

  // Transmitter model: lane words {w1,w2,w3} for one pixel.
  function automatic logic [20:0] pack(input logic [20:0] p);
    logic [5:0] r, g, b;
    logic h, v, d;
    {r, g, b, h, v, d} = p;
    return {r[0], r[1], r[2], r[3], r[4], r[5], g[0],
            g[1], g[2], g[3], g[4], g[5], b[0], b[1],
            b[2], b[3], b[4], b[5], h, v, d};
  endfunction

  // Pixel number k of an incrementing test stream.
  function automatic logic [20:0] pix(input int k);
    logic [5:0] r, g, b;
    r = 6'(k + 1);
    g = 6'(2 * k + 5);
    b = 6'(63 - k);
    return {r, g, b, k[0], k[1], 1'b1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b1, input logic b2, input logic b3, input logic bc);
    bus.channel1_in = b1;
    bus.channel2_in = b2;
    bus.channel3_in = b3;
    bus.clock_in    = bc;
    @(negedge clk);
    last_edge = cyc;
  endtask

  task automatic send_word(input logic [6:0] w1, input logic [6:0] w2,
                           input logic [6:0] w3, input logic [6:0] wc);
    for (int i = 0; i < 7; i++) begin
      send_bit(w1[6], w2[6], w3[6], wc[6]);
      w1 = w1 << 1;
      w2 = w2 << 1;
      w3 = w3 << 1;
      wc = wc << 1;
    end
  endtask

  task automatic send_pixel(input logic [20:0] p, input logic [6:0] wc);
    logic [20:0] w;
    w = pack(p);
    send_word(w[20:14], w[13:7], w[6:0], wc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    sv_cyc.delete();
    sv_pix.delete();
    rise_cyc.delete();
    fall_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.channel1_in = 1'b0;
    bus.channel2_in = 1'b0;
    bus.channel3_in = 1'b0;
    bus.clock_in    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  initial begin
    int e0;
    int f;
    int ks4[5];
    int ks5[6];

    // Reset state
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_locked", bus.locked, 1'b0);
    check("rst_valid", bus.pixel_valid, 1'b0);
    check("rst_pixel", out_pix(), 21'd0);
    check("rst_state", dut.state, SEARCH);

    // 1: clean stream, hand-packed words for P1
    do_reset();
    e0 = 0;
    for (int k = 0; k < 8; k++) begin
      send_word(7'h2B, 7'h28, 7'h7D, CP);
      if (k == 0) e0 = last_edge;
    end
    idle(3);
    check("t1_lock_rise", q_at(rise_cyc, 0), e0 + 22);
    check("t1_strobes", sv_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_strobe_cyc", q_at(sv_cyc, i), e0 + 29 + 7 * i);
      check("t1_pixel", pix_at(i), P1);
    end

    // 2: three stray bits, then incrementing pixels
    do_reset();
    send_bit(1'b0, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      send_pixel(pix(k), CP);
      if (k == 0) e0 = last_edge;
    end
    idle(3);
    check("t2_lock_rise", q_at(rise_cyc, 0), e0 + 22);
    check("t2_strobes", sv_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_strobe_cyc", q_at(sv_cyc, i), e0 + 29 + 7 * i);
      check("t2_pixel", pix_at(i), pix(4 + i));
    end

    // 3: pattern at a wrong offset, true framing two bits later
    do_reset();
    send_word(7'h00, 7'h00, 7'h00, CP);
    f = last_edge;
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_verify", dut.state, VERIFY);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    send_pixel(P1, CP);
    e0 = last_edge;
    check("t3_back_search", dut.state, SEARCH);
    for (int k = 1; k < 8; k++) send_pixel(P1, CP);
    idle(3);
    check("t3_lock_rise", q_at(rise_cyc, 0), f + 9 + 22);
    check("t3_strobes", sv_cyc.size(), 4);
    check("t3_first_strobe", q_at(sv_cyc, 0), e0 + 29);
    for (int i = 0; i < 4; i++) check("t3_pixel", pix_at(i), P1);

    // 4: one bad clock word while locked
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send_pixel(pix(k), (k == 6) ? BAD_CP : CP);
      if (k == 0) begin
        e0 = last_edge;
        snap_at = e0 + 43;
      end
    end
    check("t4_no_fall", fall_cyc.size(), 0);
    check("t4_locked", bus.locked, 1'b1);
    idle(3);
    ks4 = '{4, 5, 7, 8, 9};
    check("t4_strobes", sv_cyc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("t4_strobe_cyc", q_at(sv_cyc, i), e0 + 7 * ks4[i] + 1);
      check("t4_pixel", pix_at(i), pix(ks4[i]));
    end
    check("t4_hold_pixel", snap_pix, pix(5));
    check("t4_hold_valid", snap_valid, 1'b0);
    check("t4_hold_locked", snap_locked, 1'b1);
    snap_at = -1;

    // 5: two consecutive bad words, then clean relock
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send_pixel(pix(k), (k == 6 || k == 7) ? 7'b0000000 : CP);
      if (k == 0) e0 = last_edge;
    end
    idle(3);
    check("t5_lock_rise", q_at(rise_cyc, 0), e0 + 22);
    check("t5_lock_fall", q_at(fall_cyc, 0), e0 + 50);
    check("t5_relock", q_at(rise_cyc, 1), e0 + 78);
    ks5 = '{4, 5, 12, 13, 14, 15};
    check("t5_strobes", sv_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t5_strobe_cyc", q_at(sv_cyc, i), e0 + 7 * ks5[i] + 1);
      check("t5_pixel", pix_at(i), pix(ks5[i]));
    end

    // 6: asynchronous reset mid-word while locked
    do_reset();
    for (int k = 0; k < 6; k++) send_pixel(pix(k), CP);
    send_bit(1'b1, 1'b0, 1'b1, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_pre_locked", bus.locked, 1'b1);
    check("t6_pre_pixel", out_pix(), pix(5));
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_pixel", out_pix(), 21'd0);
    check("t6_rst_locked", bus.locked, 1'b0);
    check("t6_rst_valid", bus.pixel_valid, 1'b0);
    check("t6_rst_state", dut.state, SEARCH);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 8; k++) begin
      send_pixel(pix(k + 20), CP);
      if (k == 0) e0 = last_edge;
    end
    idle(3);
    check("t6_relock", q_at(rise_cyc, 0), e0 + 22);
    check("t6_strobes", sv_cyc.size(), 4);
    for (int i = 0; i < 4; i++) check("t6_pixel", pix_at(i), pix(24 + i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
